// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the fetch stage.
// Produces the fetch address with a valid/ready handshake, a trap/jump
// redirect (trap wins), a BOOT/RUN/HALT FSM and 2- or 4-byte increments.
// Optional return-address stack is enabled by defining PC_GEN_RAS_EN;
// without it the call/ret hints are ignored and ras_hit/ras_count read 0.
module pc_gen #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
    parameter int              RVC_SUPPORT  = 0,
    parameter int              RAS_DEPTH    = 4,
    localparam int             CW           = $clog2(RAS_DEPTH) + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall_n,
    input  logic            trap_en,
    input  logic [XLEN-1:0] trap_addr,
    input  logic            jump_en,
    input  logic [XLEN-1:0] jump_addr,
    input  logic            halt_req,
    input  logic            resume_req,
    input  logic            is_compressed,
    input  logic            call_hint,
    input  logic            ret_hint,
    input  logic            fetch_ready,
    output logic            fetch_valid,
    output logic [XLEN-1:0] pc,
    output logic            ras_hit,
    output logic [CW-1:0]   ras_count
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_e;

    state_e          state_r;
    state_e          state_nxt_s;
    logic [XLEN-1:0] pc_r;
    logic [XLEN-1:0] pc_nxt_s;
    logic            fetch_valid_r;
    logic            ras_hit_r;
    logic            hit_nxt_s;
    logic            fire_s;
    logic [XLEN-1:0] inc_s;
    logic [XLEN-1:0] seq_pc_s;
    logic            push_s;
    logic            pop_s;
    logic [XLEN-1:0] ras_top_s;
    logic            ras_avail_s;
    logic            call_s;
    logic            ret_s;

    // Redirect targets are halfword aligned with RVC, word aligned without.
    function automatic logic [XLEN-1:0] align_target(input logic [XLEN-1:0] addr);
        logic [XLEN-1:0] res;
        res    = addr;
        res[0] = 1'b0;
        if (RVC_SUPPORT == 0) begin
            res[1] = 1'b0;
        end else begin
            res[1] = addr[1];
        end
        return res;
    endfunction

    assign fire_s   = fetch_valid_r & fetch_ready & stall_n;
    assign seq_pc_s = pc_r + inc_s;

    // Sequential step size: 2 only for a compressed instruction on an RVC core.
    always_comb begin
        inc_s = {{(XLEN-3){1'b0}}, 3'd4};
        if ((RVC_SUPPORT != 0) && is_compressed) begin
            inc_s = {{(XLEN-3){1'b0}}, 3'd2};
        end else begin
            inc_s = {{(XLEN-3){1'b0}}, 3'd4};
        end
    end

    // Next-state, next-pc and RAS push/pop decisions.
    always_comb begin
        state_nxt_s = state_r;
        pc_nxt_s    = pc_r;
        hit_nxt_s   = ras_hit_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        case (state_r)
            ST_BOOT: begin
                state_nxt_s = ST_RUN;
            end
            ST_RUN: begin
                // A trap in the same cycle overrides a halt request.
                if (halt_req && !trap_en) begin
                    state_nxt_s = ST_HALT;
                end else begin
                    state_nxt_s = ST_RUN;
                end
                if (trap_en) begin
                    pc_nxt_s  = align_target(trap_addr);
                    hit_nxt_s = 1'b0;
                end else if (jump_en) begin
                    pc_nxt_s  = align_target(jump_addr);
                    hit_nxt_s = 1'b0;
                end else if (fire_s) begin
                    push_s = call_s;
                    pop_s  = ret_s & ras_avail_s;
                    if (pop_s) begin
                        pc_nxt_s  = ras_top_s;
                        hit_nxt_s = 1'b1;
                    end else begin
                        pc_nxt_s  = seq_pc_s;
                        hit_nxt_s = 1'b0;
                    end
                end else begin
                    pc_nxt_s = pc_r;
                end
            end
            ST_HALT: begin
                if (trap_en) begin
                    pc_nxt_s    = align_target(trap_addr);
                    hit_nxt_s   = 1'b0;
                    state_nxt_s = ST_RUN;
                end else if (resume_req) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_HALT;
                end
            end
            default: begin
                state_nxt_s = ST_BOOT;
                pc_nxt_s    = RESET_VECTOR;
                hit_nxt_s   = 1'b0;
            end
        endcase
    end

    // State, pc and handshake registers; fetch_valid follows the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_BOOT;
            pc_r          <= RESET_VECTOR;
            fetch_valid_r <= 1'b0;
            ras_hit_r     <= 1'b0;
        end else begin
            state_r       <= state_nxt_s;
            pc_r          <= pc_nxt_s;
            fetch_valid_r <= (state_nxt_s == ST_RUN);
            ras_hit_r     <= hit_nxt_s;
        end
    end

    assign fetch_valid = fetch_valid_r;
    assign pc          = pc_r;
    assign ras_hit     = ras_hit_r;

`ifdef PC_GEN_RAS_EN
    localparam int PW = $clog2(RAS_DEPTH);

    logic [XLEN-1:0] ras_mem_r [RAS_DEPTH];
    logic [PW-1:0]   ras_ptr_r;
    logic [CW-1:0]   ras_count_r;
    logic [PW-1:0]   top_idx_s;

    // ras_ptr_r is the next write slot; the top of stack sits just below it.
    assign top_idx_s   = ras_ptr_r - PW'(1'b1);
    assign ras_top_s   = ras_mem_r[top_idx_s];
    assign ras_avail_s = (ras_count_r != {CW{1'b0}});
    assign call_s      = call_hint;
    assign ret_s       = ret_hint;
    assign ras_count   = ras_count_r;

    // Circular return-address stack; a full push overwrites the oldest slot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ras_ptr_r   <= {PW{1'b0}};
            ras_count_r <= {CW{1'b0}};
            for (int i = 0; i < RAS_DEPTH; i++) begin
                ras_mem_r[i] <= {XLEN{1'b0}};
            end
        end else if (push_s && pop_s) begin
            ras_mem_r[top_idx_s] <= seq_pc_s;
        end else if (push_s) begin
            ras_mem_r[ras_ptr_r] <= seq_pc_s;
            ras_ptr_r            <= ras_ptr_r + PW'(1'b1);
            if (ras_count_r != CW'(RAS_DEPTH)) begin
                ras_count_r <= ras_count_r + CW'(1'b1);
            end else begin
                ras_count_r <= ras_count_r;
            end
        end else if (pop_s) begin
            ras_ptr_r   <= top_idx_s;
            ras_count_r <= ras_count_r - CW'(1'b1);
        end else begin
            ras_ptr_r   <= ras_ptr_r;
            ras_count_r <= ras_count_r;
        end
    end
`else
    logic unused_ras_s;

    assign ras_top_s    = {XLEN{1'b0}};
    assign ras_avail_s  = 1'b0;
    assign call_s       = 1'b0;
    assign ret_s        = 1'b0;
    assign ras_count    = {CW{1'b0}};
    assign unused_ras_s = call_hint | ret_hint | push_s | pop_s;
`endif

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed, table-driven bench for pc_gen.
// Two instances share stimulus: one with RVC_SUPPORT=1, one with RVC_SUPPORT=0,
// both RESET_VECTOR=0x100 and RAS_DEPTH=4.
module tb_pc_gen;

`ifdef PC_GEN_RAS_EN
    localparam bit RAS_ON = 1'b1;
`else
    localparam bit RAS_ON = 1'b0;
`endif

    typedef struct {
        logic        trap_en;
        logic [31:0] trap_addr;
        logic        jump_en;
        logic [31:0] jump_addr;
        logic        ready;
        logic        stall_n;
        logic        halt;
        logic        resume;
        logic        comp;
        logic        call;
        logic        ret;
        logic        exp_v;
        logic [31:0] exp_pc1;
        logic [31:0] exp_pc0;
        logic        exp_hit;
        logic [2:0]  exp_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_n, trap_en, jump_en, halt_req, resume_req;
    logic        is_compressed, call_hint, ret_hint, fetch_ready;
    logic [31:0] trap_addr, jump_addr;
    logic        fv1, fv0, hit1, hit0;
    logic [31:0] pc1, pc0;
    logic [2:0]  cnt1, cnt0;

    int n_vec  = 0;
    int n_miss = 0;
    int id     = 0;
    vec_t tbl[$];
    vec_t v;

    always #5 clk = ~clk;

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .RVC_SUPPORT(1), .RAS_DEPTH(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .stall_n(stall_n), .trap_en(trap_en), .trap_addr(trap_addr),
        .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req), .resume_req(resume_req),
        .is_compressed(is_compressed), .call_hint(call_hint), .ret_hint(ret_hint),
        .fetch_ready(fetch_ready), .fetch_valid(fv1), .pc(pc1), .ras_hit(hit1), .ras_count(cnt1));

    pc_gen #(.XLEN(32), .RESET_VECTOR(32'h100), .RVC_SUPPORT(0), .RAS_DEPTH(4)) dut0 (
        .clk(clk), .rst_n(rst_n), .stall_n(stall_n), .trap_en(trap_en), .trap_addr(trap_addr),
        .jump_en(jump_en), .jump_addr(jump_addr), .halt_req(halt_req), .resume_req(resume_req),
        .is_compressed(is_compressed), .call_hint(call_hint), .ret_hint(ret_hint),
        .fetch_ready(fetch_ready), .fetch_valid(fv0), .pc(pc0), .ras_hit(hit0), .ras_count(cnt0));

    // Default (idle, ready) inputs with the given expected outputs.
    function automatic vec_t mk(input logic ev, input logic [31:0] p1, input logic [31:0] p0,
                                input logic eh, input logic [2:0] ec);
        vec_t r;
        r.trap_en = 1'b0; r.trap_addr = 32'h0; r.jump_en = 1'b0; r.jump_addr = 32'h0;
        r.ready = 1'b1; r.stall_n = 1'b1; r.halt = 1'b0; r.resume = 1'b0;
        r.comp = 1'b0; r.call = 1'b0; r.ret = 1'b0;
        r.exp_v = ev; r.exp_pc1 = p1; r.exp_pc0 = p0; r.exp_hit = eh; r.exp_cnt = ec;
        return r;
    endfunction

    task automatic check_now(input vec_t e, input int tag);
        n_vec++;
        if (fv1 !== e.exp_v)   begin n_miss++; $display("FAIL vec%0d valid_rvc got %b want %b", tag, fv1, e.exp_v); end
        if (fv0 !== e.exp_v)   begin n_miss++; $display("FAIL vec%0d valid_norvc got %b want %b", tag, fv0, e.exp_v); end
        if (pc1 !== e.exp_pc1) begin n_miss++; $display("FAIL vec%0d pc_rvc got %h want %h", tag, pc1, e.exp_pc1); end
        if (pc0 !== e.exp_pc0) begin n_miss++; $display("FAIL vec%0d pc_norvc got %h want %h", tag, pc0, e.exp_pc0); end
        if (hit1 !== e.exp_hit || hit0 !== e.exp_hit) begin
            n_miss++; $display("FAIL vec%0d ras_hit got %b/%b want %b", tag, hit1, hit0, e.exp_hit);
        end
        if (cnt1 !== e.exp_cnt || cnt0 !== e.exp_cnt) begin
            n_miss++; $display("FAIL vec%0d ras_count got %0d/%0d want %0d", tag, cnt1, cnt0, e.exp_cnt);
        end
    endtask

    // Drive at negedge, clock once, compare at the following negedge.
    task automatic apply(input vec_t e, input int tag);
        trap_en = e.trap_en; trap_addr = e.trap_addr; jump_en = e.jump_en; jump_addr = e.jump_addr;
        fetch_ready = e.ready; stall_n = e.stall_n; halt_req = e.halt; resume_req = e.resume;
        is_compressed = e.comp; call_hint = e.call; ret_hint = e.ret;
        @(posedge clk);
        @(negedge clk);
        check_now(e, tag);
    endtask

    task automatic run(input vec_t e);
        apply(e, id);
        id++;
    endtask

    initial begin
        rst_n = 1'b0;
        v = mk(1'b0, 32'h0, 32'h0, 1'b0, 3'd0);
        trap_en = 1'b0; trap_addr = 32'h0; jump_en = 1'b0; jump_addr = 32'h0;
        fetch_ready = 1'b1; stall_n = 1'b1; halt_req = 1'b0; resume_req = 1'b0;
        is_compressed = 1'b0; call_hint = 1'b0; ret_hint = 1'b0;

        // ---- vector table ----
        tbl.push_back(mk(1'b1, 32'h100, 32'h100, 1'b0, 3'd0));                 // BOOT -> RUN
        tbl.push_back(mk(1'b1, 32'h104, 32'h104, 1'b0, 3'd0));
        tbl.push_back(mk(1'b1, 32'h108, 32'h108, 1'b0, 3'd0));
        v = mk(1'b1, 32'h200, 32'h200, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h200; tbl.push_back(v);
        v = mk(1'b1, 32'h202, 32'h204, 1'b0, 3'd0); v.comp = 1'b1; tbl.push_back(v);
        v = mk(1'b1, 32'h206, 32'h208, 1'b0, 3'd0); tbl.push_back(v);
        v = mk(1'b1, 32'h208, 32'h20C, 1'b0, 3'd0); v.comp = 1'b1; tbl.push_back(v);
        v = mk(1'b1, 32'h40, 32'h40, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h40; tbl.push_back(v);
        for (int i = 0; i < 3; i++) begin
            v = mk(1'b1, 32'h40, 32'h40, 1'b0, 3'd0); v.ready = 1'b0; tbl.push_back(v);
        end
        v = mk(1'b1, 32'h40, 32'h40, 1'b0, 3'd0); v.stall_n = 1'b0; tbl.push_back(v);
        v = mk(1'b1, 32'h44, 32'h44, 1'b0, 3'd0); v.stall_n = 1'b0; v.jump_en = 1'b1; v.jump_addr = 32'h44; tbl.push_back(v);
        v = mk(1'b1, 32'h800, 32'h800, 1'b0, 3'd0);
        v.trap_en = 1'b1; v.trap_addr = 32'h800; v.jump_en = 1'b1; v.jump_addr = 32'h300; tbl.push_back(v);
        v = mk(1'b1, 32'h302, 32'h300, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h303; tbl.push_back(v);
        v = mk(1'b1, 32'h80, 32'h80, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h80; tbl.push_back(v);
        v = mk(1'b0, 32'h80, 32'h80, 1'b0, 3'd0); v.halt = 1'b1; v.ready = 1'b0; tbl.push_back(v);
        v = mk(1'b0, 32'h80, 32'h80, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h300; tbl.push_back(v);
        tbl.push_back(mk(1'b0, 32'h80, 32'h80, 1'b0, 3'd0));
        v = mk(1'b1, 32'h1C0, 32'h1C0, 1'b0, 3'd0); v.trap_en = 1'b1; v.trap_addr = 32'h1C0; tbl.push_back(v);
        v = mk(1'b0, 32'h1C0, 32'h1C0, 1'b0, 3'd0); v.halt = 1'b1; v.ready = 1'b0; tbl.push_back(v);
        v = mk(1'b1, 32'h1C0, 32'h1C0, 1'b0, 3'd0); v.resume = 1'b1; tbl.push_back(v);
        tbl.push_back(mk(1'b1, 32'h1C4, 32'h1C4, 1'b0, 3'd0));
        v = mk(1'b1, 32'h600, 32'h600, 1'b0, 3'd0); v.halt = 1'b1; v.trap_en = 1'b1; v.trap_addr = 32'h600; tbl.push_back(v);
        v = mk(1'b1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'hFFFF_FFFC; tbl.push_back(v);
        tbl.push_back(mk(1'b1, 32'h0, 32'h0, 1'b0, 3'd0));                     // wrap

        // ---- reset state and BOOT cycle ----
        @(negedge clk);
        check_now(mk(1'b0, 32'h100, 32'h100, 1'b0, 3'd0), 900);
        rst_n = 1'b1;
        check_now(mk(1'b0, 32'h100, 32'h100, 1'b0, 3'd0), 901);

        for (int i = 0; i < tbl.size(); i++) begin
            run(tbl[i]);
        end

        // ---- RAS sequences ----
        v = mk(1'b1, 32'h10, 32'h10, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h10; run(v);
`ifdef PC_GEN_RAS_EN
        v = mk(1'b1, 32'h14, 32'h14, 1'b0, 3'd1); v.call = 1'b1; run(v);
        v = mk(1'b1, 32'h20, 32'h20, 1'b0, 3'd1); v.jump_en = 1'b1; v.jump_addr = 32'h20; run(v);
        v = mk(1'b1, 32'h24, 32'h24, 1'b0, 3'd2); v.call = 1'b1; run(v);
        v = mk(1'b1, 32'h24, 32'h24, 1'b1, 3'd1); v.ret = 1'b1; run(v);
        v = mk(1'b1, 32'h14, 32'h14, 1'b1, 3'd0); v.ret = 1'b1; run(v);
        v = mk(1'b1, 32'h14, 32'h14, 1'b1, 3'd0); v.ready = 1'b0; run(v);   // hit holds
        v = mk(1'b1, 32'h18, 32'h18, 1'b0, 3'd0); v.ret = 1'b1; run(v);     // empty pop
        // five pushes: 0x1C,0x20,0x24,0x28 then 0x2C overwrites 0x1C
        for (int i = 0; i < 5; i++) begin
            v = mk(1'b1, 32'h1C + 32'(4 * i), 32'h1C + 32'(4 * i), 1'b0, (i < 4) ? 3'(i + 1) : 3'd4);
            v.call = 1'b1; run(v);
        end
        for (int i = 0; i < 4; i++) begin
            v = mk(1'b1, 32'h2C - 32'(4 * i), 32'h2C - 32'(4 * i), 1'b1, 3'(3 - i));
            v.ret = 1'b1; run(v);
        end
        v = mk(1'b1, 32'h24, 32'h24, 1'b0, 3'd0); v.ret = 1'b1; run(v);     // oldest lost
        v = mk(1'b1, 32'h28, 32'h28, 1'b0, 3'd1); v.call = 1'b1; run(v);
        v = mk(1'b1, 32'h28, 32'h28, 1'b1, 3'd1); v.call = 1'b1; v.ret = 1'b1; run(v);
        v = mk(1'b1, 32'h2C, 32'h2C, 1'b1, 3'd0); v.ret = 1'b1; run(v);
        v = mk(1'b1, 32'h30, 32'h30, 1'b0, 3'd1); v.call = 1'b1; run(v);
        v = mk(1'b1, 32'h100, 32'h100, 1'b0, 3'd1); v.ret = 1'b1; v.trap_en = 1'b1; v.trap_addr = 32'h100; run(v);
        v = mk(1'b1, 32'h30, 32'h30, 1'b1, 3'd0); v.ret = 1'b1; run(v);
`else
        v = mk(1'b1, 32'h14, 32'h14, 1'b0, 3'd0); v.call = 1'b1; run(v);
        v = mk(1'b1, 32'h18, 32'h18, 1'b0, 3'd0); v.ret = 1'b1; run(v);
`endif

        // ---- asynchronous reset mid-operation ----
        v = mk(1'b1, 32'h500, 32'h500, 1'b0, 3'd0); v.jump_en = 1'b1; v.jump_addr = 32'h500; run(v);
        v = mk(1'b1, 32'h504, 32'h504, 1'b0, RAS_ON ? 3'd1 : 3'd0); v.call = 1'b1; run(v);
        call_hint = 1'b0;
        #2 rst_n = 1'b0;
        #1 check_now(mk(1'b0, 32'h100, 32'h100, 1'b0, 3'd0), 902);
        @(negedge clk);
        rst_n = 1'b1;
        check_now(mk(1'b0, 32'h100, 32'h100, 1'b0, 3'd0), 903);
        run(mk(1'b1, 32'h100, 32'h100, 1'b0, 3'd0));
        run(mk(1'b1, 32'h104, 32'h104, 1'b0, 3'd0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator for the RISC-V core fetch stage; successor to the fixed 32-bit, +4-only PC register.
- Adds a configurable reset vector and XLEN, and RVC-aware increments (+2/+4).
- Adds a valid/ready fetch handshake, a prioritised trap/jump redirect, a halt/resume FSM and an optional return-address stack (RAS) for return prediction.
- Sits between the branch/trap unit and the instruction-fetch bus master.

Parameters:
XLEN, 32, address width in bits
RESET_VECTOR, 0, PC value loaded on reset; low 2 bits must be 0
RVC_SUPPORT, 0, 1 enables 2-byte increments and halfword-aligned targets
RAS_DEPTH, 4, RAS entries; power of 2, >=2; used only with PC_GEN_RAS_EN

Ports:
clk  in  1  clock
rst_n  in  1  reset; asynchronous assert, active-low
stall_n  in  1  0 blocks sequential advance; redirects still apply
trap_en  in  1  trap redirect; highest priority
trap_addr  in  XLEN  trap target
jump_en  in  1  branch/jump redirect
jump_addr  in  XLEN  jump target
halt_req  in  1  enter HALT (WFI/debug)
resume_req  in  1  leave HALT
is_compressed  in  1  instruction at pc is 16-bit; ignored when RVC_SUPPORT=0
call_hint  in  1  instruction at pc is a call (push return address)
ret_hint  in  1  instruction at pc is a return (pop prediction)
fetch_ready  in  1  fetch master accepts pc
fetch_valid  out  1  pc is a valid fetch request
pc  out  XLEN  current fetch address
ras_hit  out  1  current pc was produced by a RAS pop
ras_count  out  $clog2(RAS_DEPTH)+1  live RAS entries

Behaviour:
- All outputs registered.
- Reset (rst_n=0, asynchronous): pc=RESET_VECTOR, state=BOOT, fetch_valid=0, ras_hit=0, ras_count=0, RAS write pointer=0.
- Reset mid-operation discards any in-flight handshake and RAS contents.

FSM:
- BOOT: one cycle with fetch_valid=0, then RUN unconditionally.
- RUN: fetch_valid=1. halt_req=1 -> HALT at next edge; fetch_valid=0 from that edge. halt_req with trap_en in the same cycle: trap wins, stay RUN.
- HALT: fetch_valid=0, pc holds; jump_en and hints ignored.
  - resume_req=1 -> RUN, pc unchanged.
  - trap_en=1 -> pc=trap_addr and go to RUN (wakes WFI).

Handshake:
- fire = fetch_valid & fetch_ready & stall_n.
- While fetch_valid=1 and fire=0, pc is stable unless a redirect occurs; a redirect abandons the pending request.

Next-pc priority (RUN), first match wins:
1. trap_en: pc=trap_addr.
2. jump_en: pc=jump_addr.
3. fire & ret_hint & ras_count>0: pc=RAS top.
4. fire: pc = pc + inc, where inc = (RVC_SUPPORT & is_compressed) ? 2 : 4.
5. Otherwise hold.

Target alignment and arithmetic:
- Redirect targets: bit0 forced to 0; bit1 also forced to 0 when RVC_SUPPORT=0.
- Increment wraps modulo 2^XLEN; 0xFFFF_FFFC + 4 = 0x0000_0000.
- ras_hit=1 only in the cycle after case 3 loads pc; cleared on any other pc update; holds while pc holds.

RAS (hints acted on only when fire=1 and no trap_en/jump_en in that cycle):
- Push on call_hint: writes pc+inc.
- Pop on ret_hint: consumes top.
- Push and pop together: target = old top; the slot is then overwritten with pc+inc; ras_count unchanged.
- Push when full: circular overwrite of the oldest entry; ras_count saturates at RAS_DEPTH.
- Pop when empty: no prediction (case 4); ras_count stays 0.
- Traps and jumps do not modify the RAS.

Optional Feature:
- PC_GEN_RAS_EN defined: RAS storage, case 3, push/pop logic and ras_hit present as above.
- Undefined: no RAS storage; call_hint/ret_hint ignored; ras_hit and ras_count tied to 0; next-pc priority skips case 3; RAS_DEPTH unused.

Test Plan:
- RESET_VECTOR=0x100; release rst_n, hold fetch_ready=1 -> fetch_valid=0 for one cycle, then pc=0x100, 0x104, 0x108 on consecutive cycles.
- RVC_SUPPORT=1, pc=0x200, is_compressed=1,0,1 with fire each cycle -> pc 0x202, 0x206, 0x208. Same stimulus with RVC_SUPPORT=0 -> 0x204, 0x208, 0x20C.
- fetch_ready=0 at pc=0x40 for 3 cycles -> pc holds 0x40. trap_en (0x800) and jump_en (0x300) in the same cycle -> pc=0x800. jump_addr=0x303 with RVC_SUPPORT=0 -> pc=0x300.
- RAS_EN, RAS_DEPTH=4: call_hint at pc 0x10 and 0x20 (inc 4), then ret_hint twice -> pc=0x24 then 0x14 with ras_hit=1 each; third ret_hint with ras_count=0 -> pc+4, ras_hit=0. Five pushes -> ras_count=4, oldest lost.
- halt_req in RUN at pc=0x80 -> fetch_valid=0, pc holds 0x80; jump_en in HALT ignored; trap_en with trap_addr=0x1C0 -> RUN, pc=0x1C0, fetch_valid=1.
- rst_n asserted while pc=0x500 and fetch_valid=1 -> immediately pc=RESET_VECTOR, fetch_valid=0, ras_count=0, without waiting for a clock edge.
